bus_bridge_burst_master: RTL and testbench

- Next-generation UART-to-bus bridge controller. It accepts framed command words from a UART receiver and queues them. It executes single or burst read/write transfers on the master-interface user port, with address auto-increment, and returns read data plus a per-command status word to the UART transmitter.
- Sits between the uart module and master_interface inside the bridge top.
- Adds the following over the previous bridge: burst length, write-data streaming, a bus timeout with error status, and command-queue overflow detection.

---
 rtl/bb_pkg.sv | 31 +++
 rtl/bb_sync_fifo.sv | 53 +++++
 rtl/bus_bridge_burst_master.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_bridge_burst_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_pkg.sv
// Shared definitions for the UART-to-bus burst bridge.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package bb_pkg;

    // Status words returned after every command (zero-extended to the data width)
    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WFETCH,
        S_ISSUE,
        S_WAIT,
        S_TXDATA,
        S_TXSTAT
    } bb_state_t;

    // Header layout: {mode, len, addr} with addr in the low bits
    localparam int HDR_ADDR_LSB = 0;

    function automatic int hdr_len_lsb(input int bb_addr_width);
        return HDR_ADDR_LSB + bb_addr_width;
    endfunction

    function automatic int hdr_mode_bit(input int bb_addr_width, input int len_width);
        return HDR_ADDR_LSB + bb_addr_width + len_width;
    endfunction

endpackage

// File: rtl/bb_sync_fifo.sv
// Synchronous FIFO holding rx command/data words until the bridge FSM consumes them.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: push when full is dropped unless a pop frees a slot on the same edge.
module bb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/bus_bridge_burst_master.sv
// UART-to-bus bridge: queues framed commands, runs single/burst bus transfers, returns read data and status.
// Latency: header at queue head -> mwvalid 3 cycles later for a read with mready=1.
// Backpressure: rx words dropped (sticky overflow) when the queue is full; tx waits on tx_busy; ISSUE waits on mready.
module bus_bridge_burst_master
    import bb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int BB_ADDR_WIDTH  = 13,
    parameter int LEN_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int RX_WIDTH      = 1 + LEN_WIDTH + BB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [RX_WIDTH-1:0]   rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_en,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic [DATA_WIDTH-1:0] mwdata,
    output logic                  mwvalid,
    output logic                  wen,
    input  logic                  mready,
    input  logic [DATA_WIDTH-1:0] mrdata,
    output logic                  overflow,
    output logic                  busy
);

    localparam int LEN_LSB  = hdr_len_lsb(BB_ADDR_WIDTH);
    localparam int MODE_BIT = hdr_mode_bit(BB_ADDR_WIDTH, LEN_WIDTH);
    localparam int TO_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] STAT_OK  = DATA_WIDTH'(ST_OK);
    localparam logic [DATA_WIDTH-1:0] STAT_ERR = DATA_WIDTH'(ST_TIMEOUT);

    bb_state_t             state, state_n;
    logic [RX_WIDTH-1:0]   head;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                     mode;
    logic [LEN_WIDTH-1:0]     beats;
    logic [BB_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [DATA_WIDTH-1:0]    status;
    logic                     abort;
    logic [TO_W-1:0]          tcnt;
    logic                     seen_low;
    logic [1:0]               tx_phase;

    logic pop, ld_hdr, ld_wdata, issue, beat_adv, drop_dec, cap_rd, timeout;
    logic done, tx_send, tx_leave;

    bb_sync_fifo #(
        .WIDTH (RX_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy = (state != S_IDLE) || (fifo_count != '0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        ld_hdr   = 1'b0;
        ld_wdata = 1'b0;
        issue    = 1'b0;
        beat_adv = 1'b0;
        drop_dec = 1'b0;
        cap_rd   = 1'b0;
        timeout  = 1'b0;
        tx_send  = 1'b0;
        tx_leave = 1'b0;
        // A beat completes on a low-then-high mready, or mready high two cycles after the strobe
        done     = mready && (seen_low || (tcnt >= TO_W'(2)));
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_n = S_HDR;
            end
            S_HDR: begin
                pop     = 1'b1;
                ld_hdr  = 1'b1;
                state_n = head[MODE_BIT] ? S_WFETCH : S_ISSUE;
            end
            S_WFETCH: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!abort) begin
                        ld_wdata = 1'b1;
                        state_n  = S_ISSUE;
                    end else begin
                        // Timed-out write: swallow the rest of the frame to keep framing aligned
                        drop_dec = 1'b1;
                        if (beats == LEN_WIDTH'(1)) state_n = S_TXSTAT;
                    end
                end
            end
            S_ISSUE: begin
                if (mready) begin
                    issue   = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    if (!mode) begin
                        cap_rd  = 1'b1;
                        state_n = S_TXDATA;
                    end else if (beats != '0) begin
                        beat_adv = 1'b1;
                        state_n  = S_WFETCH;
                    end else begin
                        state_n = S_TXSTAT;
                    end
                end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_n = (mode && (beats != '0)) ? S_WFETCH : S_TXSTAT;
                end
            end
            S_TXDATA, S_TXSTAT: begin
                tx_send  = (tx_phase == 2'd0) && !tx_busy;
                tx_leave = (tx_phase == 2'd3) && !tx_busy;
                if (tx_leave) begin
                    if (state == S_TXSTAT) begin
                        state_n = S_IDLE;
                    end else if (beats != '0) begin
                        beat_adv = 1'b1;
                        state_n  = S_ISSUE;
                    end else begin
                        state_n = S_TXSTAT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: command fields, bus request, timeout counter, tx handshake, overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode     <= 1'b0;
            beats    <= '0;
            addr     <= '0;
            rdata    <= '0;
            status   <= '0;
            abort    <= 1'b0;
            tcnt     <= '0;
            seen_low <= 1'b0;
            tx_phase <= 2'd0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
            maddr    <= '0;
            mwdata   <= '0;
            mwvalid  <= 1'b0;
            wen      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tx_en   <= 1'b0;
            mwvalid <= 1'b0;
            if (rx_valid && fifo_full && !pop) overflow <= 1'b1;
            if (ld_hdr) begin
                mode   <= head[MODE_BIT];
                beats  <= head[LEN_LSB +: LEN_WIDTH];
                addr   <= head[HDR_ADDR_LSB +: BB_ADDR_WIDTH];
                status <= STAT_OK;
                abort  <= 1'b0;
            end
            if (ld_wdata) mwdata <= head[DATA_WIDTH-1:0];
            if (issue) begin
                mwvalid  <= 1'b1;
                wen      <= mode;
                maddr    <= ADDR_WIDTH'(addr);
                tcnt     <= '0;
                seen_low <= 1'b0;
            end else if (state == S_WAIT) begin
                tcnt <= tcnt + TO_W'(1);
                if (!mready) seen_low <= 1'b1;
            end
            if (beat_adv) begin
                beats <= beats - LEN_WIDTH'(1);
                addr  <= addr + BB_ADDR_WIDTH'(1);
            end
            if (drop_dec) beats <= beats - LEN_WIDTH'(1);
            if (cap_rd) rdata <= mrdata;
            if (timeout) begin
                status <= STAT_ERR;
                abort  <= mode && (beats != '0);
            end
            // tx_phase: 0 idle, 1 strobe cycle, 2 busy-ignore cycle, 3 wait for tx_busy low
            if (tx_send) begin
                tx_en    <= 1'b1;
                tx_data  <= (state == S_TXDATA) ? rdata : status;
                tx_phase <= 2'd1;
            end else if (tx_phase == 2'd1 || tx_phase == 2'd2) begin
                tx_phase <= tx_phase + 2'd1;
            end else if (tx_leave) begin
                tx_phase <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_bus_bridge_burst_master.sv
// Directed bench for bus_bridge_burst_master with scoreboard queues for bus beats and tx words.
// Latency: n/a.
// Backpressure: bench models a UART transmitter busy window and a bus slave with settable stalls.
module tb_bus_bridge_burst_master;

    typedef struct packed {
        logic [15:0] addr;
        logic        wen;
        logic [7:0]  dat;
    } bus_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [17:0] rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic [15:0] maddr;
    logic [7:0]  mwdata;
    logic        mwvalid;
    logic        wen;
    logic        mready;
    logic [7:0]  mrdata;
    logic        overflow;
    logic        busy;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rdq[$];
    int         ncmp = 0;
    int         nfail = 0;
    int         bus_cnt = 0;
    int         tx_cnt = 0;
    logic       hang_next = 1'b0;
    logic [7:0] bus_rd = 8'h00;

    always #5 clk = ~clk;

    bus_bridge_burst_master dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .maddr    (maddr),
        .mwdata   (mwdata),
        .mwvalid  (mwvalid),
        .wen      (wen),
        .mready   (mready),
        .mrdata   (mrdata),
        .overflow (overflow),
        .busy     (busy)
    );

    function automatic logic [17:0] hdr(input logic m, input logic [3:0] l, input logic [12:0] a);
        return {m, l, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        bus_t e;
        e.addr = a;
        e.wen  = w;
        e.dat  = d;
        exp_bus.push_back(e);
    endtask

    // One clock step: monitor outputs at the falling edge, then update bus slave and UART models
    task automatic tick();
        bus_t       e;
        logic [7:0] t;
        @(negedge clk);
        if (mwvalid === 1'b1) begin
            if (exp_bus.size() == 0) begin
                chk("spurious_mwvalid", 32'(mwvalid), 32'd0);
            end else begin
                e = exp_bus.pop_front();
                chk("maddr", 32'(maddr), 32'(e.addr));
                chk("wen", 32'(wen), 32'(e.wen));
                if (e.wen) chk("mwdata", 32'(mwdata), 32'(e.dat));
            end
        end
        if (tx_en === 1'b1) begin
            if (exp_tx.size() == 0) begin
                chk("spurious_tx_en", 32'(tx_en), 32'd0);
            end else begin
                t = exp_tx.pop_front();
                chk("tx_data", 32'(tx_data), 32'(t));
            end
        end
        if (bus_cnt > 0) begin
            bus_cnt--;
            if (bus_cnt == 0) begin
                mrdata = bus_rd;
                mready = 1'b1;
            end
        end else if (mwvalid === 1'b1) begin
            mready = 1'b0;
            if (hang_next) begin
                hang_next = 1'b0;
            end else begin
                bus_cnt = 3;
                bus_rd  = (!wen && rdq.size() > 0) ? rdq.pop_front() : 8'h00;
            end
        end
        if (tx_en === 1'b1) begin
            tx_busy = 1'b1;
            tx_cnt  = 4;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_busy = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [17:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        int n = 0;
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_budget_expired"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_tx_left(input int left, input int budget, input string tag);
        int n = 0;
        while (exp_tx.size() > left && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_budget_expired"}, 32'(n >= budget), 32'd0);
    endtask

    initial begin
        rstn     = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        mready   = 1'b1;
        mrdata   = 8'h00;
        repeat (3) tick();
        chk("reset_maddr", 32'(maddr), 32'd0);
        chk("reset_ctrl", 32'({tx_en, mwvalid, wen, overflow, busy}), 32'd0);
        chk("reset_data", 32'({tx_data, mwdata}), 32'd0);
        rstn = 1'b1;
        tick();

        // Single read at 0x0010, slave answers 0x5A; also checks header-to-strobe latency
        push_bus(16'h0010, 1'b0, 8'h00);
        rdq.push_back(8'h5A);
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hA5);
        send_rx(hdr(1'b0, 4'd0, 13'h0010));
        tick();
        tick();
        chk("rd_latency_early", 32'(mwvalid), 32'd0);
        tick();
        chk("rd_latency_strobe", 32'(mwvalid), 32'd1);
        run_until_quiet(200, "rd1");

        // Write burst of 4 wrapping the 13-bit address space
        send_rx(hdr(1'b1, 4'd3, 13'h1FFE));
        push_bus(16'h1FFE, 1'b1, 8'h11);
        push_bus(16'h1FFF, 1'b1, 8'h22);
        push_bus(16'h0000, 1'b1, 8'h33);
        push_bus(16'h0001, 1'b1, 8'h44);
        exp_tx.push_back(8'hA5);
        send_rx(18'h00011);
        send_rx(18'h00022);
        send_rx(18'h00033);
        send_rx(18'h00044);
        run_until_quiet(400, "wr_burst");

        // Slow write data: bridge must sit in WFETCH without issuing
        exp_tx.push_back(8'hA5);
        send_rx(hdr(1'b1, 4'd1, 13'h0200));
        for (int i = 0; i < 2; i++) begin
            repeat (2000) tick();
            chk("wfetch_busy", 32'(busy), 32'd1);
            push_bus(16'h0200 + 16'(i), 1'b1, 8'hB0 + 8'(i));
            send_rx(18'(8'hB0 + 8'(i)));
        end
        run_until_quiet(300, "wr_slow");

        // Read with a hung slave times out with 0xEE; queued read follows once the slave recovers
        hang_next = 1'b1;
        push_bus(16'h0033, 1'b0, 8'h00);
        exp_tx.push_back(8'hEE);
        send_rx(hdr(1'b0, 4'd0, 13'h0033));
        push_bus(16'h0034, 1'b0, 8'h00);
        rdq.push_back(8'hC3);
        exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hA5);
        send_rx(hdr(1'b0, 4'd0, 13'h0034));
        wait_tx_left(2, 5000, "rd_timeout");
        chk("rd_timeout_next_pending", 32'(busy), 32'd1);
        mready = 1'b1;
        run_until_quiet(300, "rd_after_timeout");

        // Write burst timing out on its first beat; remaining 3 words discarded, next header intact
        hang_next = 1'b1;
        push_bus(16'h0400, 1'b1, 8'h61);
        exp_tx.push_back(8'hEE);
        push_bus(16'h0500, 1'b0, 8'h00);
        rdq.push_back(8'h7E);
        exp_tx.push_back(8'h7E);
        exp_tx.push_back(8'hA5);
        send_rx(hdr(1'b1, 4'd3, 13'h0400));
        send_rx(18'h00061);
        send_rx(18'h00062);
        send_rx(18'h00063);
        send_rx(18'h00064);
        send_rx(hdr(1'b0, 4'd0, 13'h0500));
        wait_tx_left(2, 5000, "wr_timeout");
        mready = 1'b1;
        run_until_quiet(300, "rd_after_wr_timeout");

        // Stalled bus: fill the queue, overflow on the ninth word, then reset mid-command
        mready = 1'b0;
        send_rx(hdr(1'b0, 4'd0, 13'h0100));
        repeat (4) tick();
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_overflow_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            send_rx(hdr(1'b0, 4'd0, 13'(i)));
            if (i == 7) chk("ovf_after_8", 32'(overflow), 32'd0);
        end
        chk("ovf_after_9", 32'(overflow), 32'd1);
        repeat (20) tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_maddr", 32'(maddr), 32'd0);
        chk("midrst_ctrl", 32'({tx_en, mwvalid, wen, overflow, busy}), 32'd0);
        chk("midrst_data", 32'({tx_data, mwdata}), 32'd0);
        tick();
        tick();
        rstn   = 1'b1;
        mready = 1'b1;
        repeat (50) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_overflow", 32'(overflow), 32'd0);
        chk("post_rst_no_tx_pending", 32'(exp_tx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
